// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared FSM state type and default widths for the MVM accumulate/write-back path
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } acc_state_t;

    localparam int DEF_IWIDTH    = 32;
    localparam int DEF_OWIDTH    = 32;
    localparam int DEF_OUT_ADDRW = 8;

endpackage

// File: rtl/accum_unit.sv
// rtl/accum_unit.sv - accumulator register with first/load select; clamps when ACCUM_SATURATE_EN is defined
module accum_unit
    import mvm_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int OWIDTH = DEF_OWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     first,
    input  logic signed [IWIDTH-1:0] idata,
    output logic signed [OWIDTH-1:0] sum
);

    logic signed [OWIDTH-1:0] acc;
    logic signed [OWIDTH-1:0] ext;
    logic signed [OWIDTH-1:0] added;

    assign ext = OWIDTH'(idata);

`ifdef ACCUM_SATURATE_EN
    localparam logic signed [OWIDTH-1:0] MAX_VAL = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic signed [OWIDTH-1:0] MIN_VAL = {1'b1, {(OWIDTH-1){1'b0}}};

    logic signed [OWIDTH:0] wide;

    assign wide = {acc[OWIDTH-1], acc} + {ext[OWIDTH-1], ext};

    // Clamp when the extra sign bit disagrees with the top result bit (signed overflow)
    always_comb begin
        added = wide[OWIDTH-1:0];
        if (wide[OWIDTH] != wide[OWIDTH-1]) begin
            added = wide[OWIDTH] ? MIN_VAL : MAX_VAL;
        end
    end
`else
    assign added = acc + ext;
`endif

    // Value acc takes on this beat; also the result written when the beat is the last one
    assign sum = first ? ext : added;

    // Accumulator register: cleared at job launch, updated on every accepted beat
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/accum_wb.sv
// rtl/accum_wb.sv - dot-product accumulate and result write-back sequencer; optional clamp via ACCUM_SATURATE_EN
module accum_wb
    import mvm_pkg::*;
#(
    parameter int IWIDTH    = DEF_IWIDTH,
    parameter int OWIDTH    = DEF_OWIDTH,
    parameter int OUT_ADDRW = DEF_OUT_ADDRW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [OUT_ADDRW-1:0]     out_start_addr,
    input  logic [OUT_ADDRW:0]       out_num_results,
    input  logic                     ivalid,
    input  logic signed [IWIDTH-1:0] idata,
    input  logic                     accum_first,
    input  logic                     accum_last,
    output logic [OUT_ADDRW-1:0]     out_waddr,
    output logic [OWIDTH-1:0]        out_wdata,
    output logic                     out_wen,
    output logic                     busy,
    output logic                     done
);

    localparam int OUT_SIZEW = OUT_ADDRW + 1;
    localparam logic [OUT_SIZEW-1:0] ONE = OUT_SIZEW'(1);

    acc_state_t               state;
    logic [OUT_ADDRW-1:0]     r_start_addr;
    logic [OUT_SIZEW-1:0]     r_num_results;
    logic [OUT_SIZEW-1:0]     wcount;
    logic                     beat;
    logic                     launch;
    logic signed [OWIDTH-1:0] sum;

    // Beats count only while results are still owed; the rest of the job's beats are dropped
    assign beat   = (state == ACCUM) && ivalid && (wcount != r_num_results);
    assign launch = (state == IDLE) && start;

    accum_unit #(
        .IWIDTH (IWIDTH),
        .OWIDTH (OWIDTH)
    ) u_accum_unit (
        .clk   (clk),
        .rst   (rst),
        .clear (launch),
        .load  (beat),
        .first (accum_first),
        .idata (idata),
        .sum   (sum)
    );

    // Job FSM, write-address counter and registered write/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            r_start_addr  <= '0;
            r_num_results <= '0;
            wcount        <= '0;
            out_waddr     <= '0;
            out_wdata     <= '0;
            out_wen       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            out_wen <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r_start_addr  <= out_start_addr;
                        r_num_results <= out_num_results;
                        wcount        <= '0;
                        busy          <= 1'b1;
                        state         <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (wcount == r_num_results) begin
                        done  <= 1'b1;
                        state <= FLUSH;
                    end else if (beat && accum_last) begin
                        out_wen   <= 1'b1;
                        out_wdata <= sum;
                        out_waddr <= r_start_addr + wcount[OUT_ADDRW-1:0];
                        wcount    <= wcount + ONE;
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
